catapult_host_shim: RTL and testbench



---
 rtl/catapult_shim_pkg.sv | 19 +
 rtl/shim_sync_fifo.sv | 76 +++++++
 rtl/catapult_host_shim.sv | 166 ++++++++++++++++
 tb/tb_catapult_host_shim.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/catapult_shim_pkg.sv
// Shared constants for the Catapult host shim: CSR word addresses, CTRL bit
// positions and the default identification value.
package catapult_shim_pkg;

    localparam logic [31:0] ADDR_ID         = 32'd0;
    localparam logic [31:0] ADDR_SCRATCH    = 32'd1;
    localparam logic [31:0] ADDR_IN_COUNT   = 32'd2;
    localparam logic [31:0] ADDR_OUT_COUNT  = 32'd3;
    localparam logic [31:0] ADDR_FIFO_LEVEL = 32'd4;
    localparam logic [31:0] ADDR_CTRL       = 32'd5;
    localparam logic [31:0] ADDR_OUT_STALL  = 32'd6;
    localparam logic [31:0] ADDR_IN_STALL   = 32'd7;

    localparam int CTRL_LOOPBACK_BIT = 0;
    localparam int CTRL_CLEAR_BIT    = 1;

    localparam logic [63:0] SHIM_ID_DEFAULT = 64'hCA7A_0001_5EED_0001;

endpackage

// File: rtl/shim_sync_fifo.sv
// Synchronous valid/ready FIFO with registered flags and a separate level
// counter; no write-to-read bypass, so data appears one cycle after the push.
module shim_sync_fifo #(
    parameter int WIDTH = 640,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [WIDTH-1:0]         i_in_data,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [WIDTH-1:0]         o_out_data,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             r_in_ready;
    logic             r_out_valid;

    logic             w_push;
    logic             w_pop;
    logic [LW-1:0]    w_level_nxt;

    // Handshake decode and next-level computation.
    always_comb begin
        w_push = i_in_valid && r_in_ready;
        w_pop  = r_out_valid && i_out_ready;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + LW'(1'b1);
            2'b01:   w_level_nxt = r_level - LW'(1'b1);
            default: w_level_nxt = r_level;
        endcase
    end

    // Pointers, level and the registered full/empty flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= {AW{1'b0}};
            r_rd_ptr    <= {AW{1'b0}};
            r_level     <= {LW{1'b0}};
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1'b1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1'b1);
            end
            r_level     <= w_level_nxt;
            r_in_ready  <= (w_level_nxt != LW'(DEPTH));
            r_out_valid <= (w_level_nxt != {LW{1'b0}});
        end
    end

    // Storage is not reset; the level counter alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_in_data;
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_mem[r_rd_ptr];
    assign o_level     = r_level;

endmodule

// File: rtl/catapult_host_shim.sv
// Catapult host shim: PCIe loopback through shim_sync_fifo plus a soft-register
// CSR bank. Define CATAPULT_SHIM_PERF_EN to add the OUT_STALL/IN_STALL counters.
module catapult_host_shim
    import catapult_shim_pkg::*;
#(
    parameter int          PCIE_WIDTH         = 640,
    parameter int          SOFTREG_ADDR_WIDTH = 32,
    parameter int          SOFTREG_DATA_WIDTH = 64,
    parameter int          FIFO_DEPTH         = 16,
    parameter logic [63:0] SHIM_ID            = SHIM_ID_DEFAULT
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          io_pcie_in_valid,
    output logic                          io_pcie_in_ready,
    input  logic [PCIE_WIDTH-1:0]         io_pcie_in_bits,
    output logic                          io_pcie_out_valid,
    input  logic                          io_pcie_out_ready,
    output logic [PCIE_WIDTH-1:0]         io_pcie_out_bits,
    input  logic                          io_softreg_req_valid,
    output logic                          io_softreg_req_ready,
    input  logic [SOFTREG_ADDR_WIDTH-1:0] io_softreg_req_bits_addr,
    input  logic [SOFTREG_DATA_WIDTH-1:0] io_softreg_req_bits_wdata,
    input  logic                          io_softreg_req_bits_wr,
    output logic                          io_softreg_resp_valid,
    input  logic                          io_softreg_resp_ready,
    output logic [SOFTREG_DATA_WIDTH-1:0] io_softreg_resp_bits_rdata
);

    localparam int DW = SOFTREG_DATA_WIDTH;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic          r_ctrl_en;
    logic [DW-1:0] r_scratch;
    logic [DW-1:0] r_in_count;
    logic [DW-1:0] r_out_count;
    logic          r_resp_valid;
    logic [DW-1:0] r_rdata;

    logic          w_fifo_in_ready;
    logic [LW-1:0] w_fifo_level;
    logic          w_in_fire;
    logic          w_out_fire;
    logic          w_req_fire;
    logic          w_wr_fire;
    logic          w_rd_fire;
    logic          w_ctrl_wr;
    logic          w_clr;
    logic [DW-1:0] w_rdata_nxt;

    shim_sync_fifo #(
        .WIDTH (PCIE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_loopback_fifo (
        .clk         (clock),
        .rst         (reset),
        .i_in_valid  (io_pcie_in_valid && r_ctrl_en),
        .o_in_ready  (w_fifo_in_ready),
        .i_in_data   (io_pcie_in_bits),
        .o_out_valid (io_pcie_out_valid),
        .i_out_ready (io_pcie_out_ready),
        .o_out_data  (io_pcie_out_bits),
        .o_level     (w_fifo_level)
    );

    // Readies depend only on registered state, never on a valid.
    assign io_pcie_in_ready           = r_ctrl_en && w_fifo_in_ready;
    assign io_softreg_req_ready       = !r_resp_valid;
    assign io_softreg_resp_valid      = r_resp_valid;
    assign io_softreg_resp_bits_rdata = r_rdata;

    // Handshake and CSR write decode.
    always_comb begin
        w_in_fire  = io_pcie_in_valid && io_pcie_in_ready;
        w_out_fire = io_pcie_out_valid && io_pcie_out_ready;
        w_req_fire = io_softreg_req_valid && !r_resp_valid;
        w_wr_fire  = w_req_fire && io_softreg_req_bits_wr;
        w_rd_fire  = w_req_fire && !io_softreg_req_bits_wr;
        w_ctrl_wr  = w_wr_fire &&
                     (io_softreg_req_bits_addr == SOFTREG_ADDR_WIDTH'(ADDR_CTRL));
        w_clr      = w_ctrl_wr && io_softreg_req_bits_wdata[CTRL_CLEAR_BIT];
    end

`ifdef CATAPULT_SHIM_PERF_EN
    logic [DW-1:0] r_out_stall;
    logic [DW-1:0] r_in_stall;

    // Backpressure counters; a clear takes priority over a stall cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_stall <= {DW{1'b0}};
            r_in_stall  <= {DW{1'b0}};
        end else begin
            if (w_clr) begin
                r_out_stall <= {DW{1'b0}};
            end else if (io_pcie_out_valid && !io_pcie_out_ready) begin
                r_out_stall <= r_out_stall + DW'(1'b1);
            end else begin
                r_out_stall <= r_out_stall;
            end
            if (w_clr) begin
                r_in_stall <= {DW{1'b0}};
            end else if (io_pcie_in_valid && !io_pcie_in_ready) begin
                r_in_stall <= r_in_stall + DW'(1'b1);
            end else begin
                r_in_stall <= r_in_stall;
            end
        end
    end
`endif

    // Read mux over pre-edge register state; unmapped addresses read zero.
    always_comb begin
        w_rdata_nxt = {DW{1'b0}};
        case (io_softreg_req_bits_addr)
            SOFTREG_ADDR_WIDTH'(ADDR_ID):         w_rdata_nxt = DW'(SHIM_ID);
            SOFTREG_ADDR_WIDTH'(ADDR_SCRATCH):    w_rdata_nxt = r_scratch;
            SOFTREG_ADDR_WIDTH'(ADDR_IN_COUNT):   w_rdata_nxt = r_in_count;
            SOFTREG_ADDR_WIDTH'(ADDR_OUT_COUNT):  w_rdata_nxt = r_out_count;
            SOFTREG_ADDR_WIDTH'(ADDR_FIFO_LEVEL): w_rdata_nxt = DW'(w_fifo_level);
            SOFTREG_ADDR_WIDTH'(ADDR_CTRL):       w_rdata_nxt = DW'(r_ctrl_en) << CTRL_LOOPBACK_BIT;
`ifdef CATAPULT_SHIM_PERF_EN
            SOFTREG_ADDR_WIDTH'(ADDR_OUT_STALL):  w_rdata_nxt = r_out_stall;
            SOFTREG_ADDR_WIDTH'(ADDR_IN_STALL):   w_rdata_nxt = r_in_stall;
`endif
            default:                              w_rdata_nxt = {DW{1'b0}};
        endcase
    end

    // CSR state, beat counters and the single-outstanding read response.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ctrl_en    <= 1'b1;
            r_scratch    <= {DW{1'b0}};
            r_in_count   <= {DW{1'b0}};
            r_out_count  <= {DW{1'b0}};
            r_resp_valid <= 1'b0;
            r_rdata      <= {DW{1'b0}};
        end else begin
            if (w_ctrl_wr) begin
                r_ctrl_en <= io_softreg_req_bits_wdata[CTRL_LOOPBACK_BIT];
            end
            if (w_wr_fire &&
                (io_softreg_req_bits_addr == SOFTREG_ADDR_WIDTH'(ADDR_SCRATCH))) begin
                r_scratch <= io_softreg_req_bits_wdata;
            end
            if (w_clr) begin
                r_in_count <= {DW{1'b0}};
            end else if (w_in_fire) begin
                r_in_count <= r_in_count + DW'(1'b1);
            end
            if (w_clr) begin
                r_out_count <= {DW{1'b0}};
            end else if (w_out_fire) begin
                r_out_count <= r_out_count + DW'(1'b1);
            end
            if (w_rd_fire) begin
                r_resp_valid <= 1'b1;
                r_rdata      <= w_rdata_nxt;
            end else if (r_resp_valid && io_softreg_resp_ready) begin
                r_resp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_catapult_host_shim.sv
// Directed self-checking bench for catapult_host_shim (default parameters).
module tb_catapult_host_shim;

    localparam logic [63:0] EXP_ID = 64'hCA7A_0001_5EED_0001;

    logic         clock = 1'b0;
    logic         reset;
    logic         io_pcie_in_valid;
    logic         io_pcie_in_ready;
    logic [639:0] io_pcie_in_bits;
    logic         io_pcie_out_valid;
    logic         io_pcie_out_ready;
    logic [639:0] io_pcie_out_bits;
    logic         io_softreg_req_valid;
    logic         io_softreg_req_ready;
    logic [31:0]  io_softreg_req_bits_addr;
    logic [63:0]  io_softreg_req_bits_wdata;
    logic         io_softreg_req_bits_wr;
    logic         io_softreg_resp_valid;
    logic         io_softreg_resp_ready;
    logic [63:0]  io_softreg_resp_bits_rdata;

    int n_vec = 0;
    int n_err = 0;

    catapult_host_shim dut (
        .clock                      (clock),
        .reset                      (reset),
        .io_pcie_in_valid           (io_pcie_in_valid),
        .io_pcie_in_ready           (io_pcie_in_ready),
        .io_pcie_in_bits            (io_pcie_in_bits),
        .io_pcie_out_valid          (io_pcie_out_valid),
        .io_pcie_out_ready          (io_pcie_out_ready),
        .io_pcie_out_bits           (io_pcie_out_bits),
        .io_softreg_req_valid       (io_softreg_req_valid),
        .io_softreg_req_ready       (io_softreg_req_ready),
        .io_softreg_req_bits_addr   (io_softreg_req_bits_addr),
        .io_softreg_req_bits_wdata  (io_softreg_req_bits_wdata),
        .io_softreg_req_bits_wr     (io_softreg_req_bits_wr),
        .io_softreg_resp_valid      (io_softreg_resp_valid),
        .io_softreg_resp_ready      (io_softreg_resp_ready),
        .io_softreg_resp_bits_rdata (io_softreg_resp_bits_rdata)
    );

    always #5 clock = ~clock;

    function automatic logic [639:0] beat(input int i);
        logic [31:0] w;
        w = 32'hA5A5_0000 | 32'(i);
        return {20{w}};
    endfunction

    // Issue one CSR request from a negedge; return resp_valid/rdata seen just after acceptance.
    task automatic csr_req(input logic wr, input logic [31:0] a, input logic [63:0] wd,
                           output logic [63:0] d, output logic v);
        int t;
        io_softreg_req_valid      = 1'b1;
        io_softreg_req_bits_wr    = wr;
        io_softreg_req_bits_addr  = a;
        io_softreg_req_bits_wdata = wd;
        t = 0;
        while (!io_softreg_req_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (t >= 50) begin
            n_vec++; n_err++;
            $display("FAIL csr_timeout addr=%0d: req_ready stayed 0, need 1", a);
        end
        @(posedge clock);
        @(negedge clock);
        v = io_softreg_resp_valid;
        d = io_softreg_resp_bits_rdata;
        io_softreg_req_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [63:0] d; logic v;
        n_vec++; if (io_pcie_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b need 0", io_pcie_out_valid); end
        n_vec++; if (io_softreg_resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid: got %b need 0", io_softreg_resp_valid); end
        n_vec++; if (io_softreg_resp_bits_rdata !== 64'd0) begin n_err++; $display("FAIL rst_rdata: got %h need 0", io_softreg_resp_bits_rdata); end
        n_vec++; if (io_pcie_in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b need 1", io_pcie_in_ready); end
        n_vec++; if (io_softreg_req_ready !== 1'b1) begin n_err++; $display("FAIL rst_req_ready: got %b need 1", io_softreg_req_ready); end
        csr_req(1'b0, 32'd0, 64'd0, d, v);
        n_vec++; if (v !== 1'b1) begin n_err++; $display("FAIL id_resp_valid: got %b need 1", v); end
        n_vec++; if (d !== EXP_ID) begin n_err++; $display("FAIL id_read: got %h need %h", d, EXP_ID); end
        csr_req(1'b0, 32'd5, 64'd0, d, v);
        n_vec++; if (d !== 64'd1) begin n_err++; $display("FAIL ctrl_reset: got %h need 1", d); end
        csr_req(1'b0, 32'd9, 64'd0, d, v);
        n_vec++; if (d !== 64'd0) begin n_err++; $display("FAIL unmapped_read: got %h need 0", d); end
        csr_req(1'b0, 32'd2, 64'd0, d, v);
        n_vec++; if (d !== 64'd0) begin n_err++; $display("FAIL in_count_reset: got %h need 0", d); end
    endtask

    task automatic test_scratch();
        logic [63:0] d; logic v;
        csr_req(1'b1, 32'd1, 64'hDEAD_BEEF_0123_4567, d, v);
        n_vec++; if (v !== 1'b0) begin n_err++; $display("FAIL write_no_resp: got %b need 0", v); end
        csr_req(1'b0, 32'd1, 64'd0, d, v);
        n_vec++; if (d !== 64'hDEAD_BEEF_0123_4567) begin n_err++; $display("FAIL scratch_rb: got %h need deadbeef01234567", d); end
        csr_req(1'b1, 32'd0, 64'h1111_2222_3333_4444, d, v);
        csr_req(1'b0, 32'd0, 64'd0, d, v);
        n_vec++; if (d !== EXP_ID) begin n_err++; $display("FAIL id_readonly: got %h need %h", d, EXP_ID); end
    endtask

    task automatic test_fill_drain();
        logic [63:0] d; logic v; logic rdy; logic ov; logic [639:0] ob;
        int acc, sent, rcv, t;
        io_pcie_out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            io_pcie_in_valid = 1'b1;
            io_pcie_in_bits  = beat(acc);
            rdy = io_pcie_in_ready;
            @(posedge clock);
            if (rdy) acc++;
            @(negedge clock);
        end
        io_pcie_in_bits = beat(acc);
        n_vec++; if (acc !== 16) begin n_err++; $display("FAIL fill_accepted: got %0d need 16", acc); end
        n_vec++; if (io_pcie_in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready: got %b need 0", io_pcie_in_ready); end
        n_vec++; if (io_pcie_out_bits !== beat(0)) begin n_err++; $display("FAIL head_bits: got %h need %h", io_pcie_out_bits[31:0], 32'hA5A5_0000); end
        csr_req(1'b0, 32'd4, 64'd0, d, v);
        n_vec++; if (d !== 64'd16) begin n_err++; $display("FAIL level_full: got %0d need 16", d); end
        io_pcie_out_ready = 1'b1;
        sent = acc; rcv = 0; t = 0;
        while (rcv < 20 && t < 200) begin
            io_pcie_in_valid = (sent < 20);
            io_pcie_in_bits  = beat(sent);
            rdy = io_pcie_in_ready;
            ov  = io_pcie_out_valid;
            ob  = io_pcie_out_bits;
            @(posedge clock);
            if (rdy && sent < 20) sent++;
            if (ov) begin
                n_vec++; if (ob !== beat(rcv)) begin n_err++; $display("FAIL drain_order beat %0d: got %h need %h", rcv, ob[31:0], 32'hA5A5_0000 | 32'(rcv)); end
                rcv++;
            end
            @(negedge clock);
            t++;
        end
        io_pcie_in_valid = 1'b0;
        n_vec++; if (rcv !== 20) begin n_err++; $display("FAIL drain_count: got %0d need 20", rcv); end
        csr_req(1'b0, 32'd2, 64'd0, d, v);
        n_vec++; if (d !== 64'd20) begin n_err++; $display("FAIL in_count: got %0d need 20", d); end
        csr_req(1'b0, 32'd3, 64'd0, d, v);
        n_vec++; if (d !== 64'd20) begin n_err++; $display("FAIL out_count: got %0d need 20", d); end
        csr_req(1'b0, 32'd4, 64'd0, d, v);
        n_vec++; if (d !== 64'd0) begin n_err++; $display("FAIL level_empty: got %0d need 0", d); end
    endtask

    task automatic test_resp_hold();
        @(negedge clock);
        io_softreg_resp_ready     = 1'b0;
        io_softreg_req_valid      = 1'b1;
        io_softreg_req_bits_wr    = 1'b0;
        io_softreg_req_bits_addr  = 32'd1;
        @(posedge clock);
        @(negedge clock);
        io_softreg_req_bits_addr = 32'd0;
        for (int k = 0; k < 3; k++) begin
            n_vec++; if (io_softreg_resp_valid !== 1'b1) begin n_err++; $display("FAIL hold_valid %0d: got %b need 1", k, io_softreg_resp_valid); end
            n_vec++; if (io_softreg_resp_bits_rdata !== 64'hDEAD_BEEF_0123_4567) begin n_err++; $display("FAIL hold_rdata %0d: got %h need deadbeef01234567", k, io_softreg_resp_bits_rdata); end
            n_vec++; if (io_softreg_req_ready !== 1'b0) begin n_err++; $display("FAIL hold_req_ready %0d: got %b need 0", k, io_softreg_req_ready); end
            @(negedge clock);
        end
        io_softreg_resp_ready = 1'b1;
        @(negedge clock);
        n_vec++; if (io_softreg_resp_valid !== 1'b0 || io_softreg_req_ready !== 1'b1) begin n_err++; $display("FAIL hold_release: got valid=%b ready=%b need 0/1", io_softreg_resp_valid, io_softreg_req_ready); end
        @(negedge clock);
        io_softreg_req_valid = 1'b0;
        n_vec++; if (io_softreg_resp_valid !== 1'b1 || io_softreg_resp_bits_rdata !== EXP_ID) begin n_err++; $display("FAIL next_req: got valid=%b rdata=%h need 1/%h", io_softreg_resp_valid, io_softreg_resp_bits_rdata, EXP_ID); end
        @(negedge clock);
    endtask

    task automatic test_perf();
        logic [63:0] d; logic v; logic [63:0] exp_stall;
        io_pcie_out_ready = 1'b0;
        csr_req(1'b1, 32'd5, 64'd3, d, v);
        io_pcie_in_valid = 1'b1;
        io_pcie_in_bits  = beat(100);
        @(posedge clock);
        @(negedge clock);
        io_pcie_in_valid = 1'b0;
        repeat (5) @(negedge clock);
        io_pcie_out_ready = 1'b1;
        n_vec++; if (io_pcie_out_bits !== beat(100)) begin n_err++; $display("FAIL perf_beat: got %h need %h", io_pcie_out_bits[31:0], 32'hA5A5_0064); end
`ifdef CATAPULT_SHIM_PERF_EN
        exp_stall = 64'd5;
`else
        exp_stall = 64'd0;
`endif
        csr_req(1'b0, 32'd6, 64'd0, d, v);
        n_vec++; if (d !== exp_stall) begin n_err++; $display("FAIL out_stall: got %0d need %0d", d, exp_stall); end
        csr_req(1'b0, 32'd7, 64'd0, d, v);
        n_vec++; if (d !== 64'd0) begin n_err++; $display("FAIL in_stall: got %0d need 0", d); end
        csr_req(1'b0, 32'd5, 64'd0, d, v);
        n_vec++; if (d !== 64'd1) begin n_err++; $display("FAIL ctrl_after_clr: got %h need 1", d); end
        csr_req(1'b0, 32'd2, 64'd0, d, v);
        n_vec++; if (d !== 64'd1) begin n_err++; $display("FAIL in_count_after_clr: got %0d need 1", d); end
    endtask

    task automatic test_ctrl();
        logic [63:0] d; logic v;
        io_pcie_out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            io_pcie_in_valid = 1'b1;
            io_pcie_in_bits  = beat(200 + k);
            @(posedge clock);
            @(negedge clock);
        end
        io_pcie_in_valid = 1'b0;
        csr_req(1'b1, 32'd5, 64'd0, d, v);
        io_pcie_in_valid = 1'b1;
        io_pcie_in_bits  = beat(300);
        n_vec++; if (io_pcie_in_ready !== 1'b0) begin n_err++; $display("FAIL ctrl_off_ready: got %b need 0", io_pcie_in_ready); end
        io_pcie_out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_vec++; if (io_pcie_out_valid !== 1'b1 || io_pcie_out_bits !== beat(200 + k) || io_pcie_in_ready !== 1'b0) begin n_err++; $display("FAIL ctrl_drain %0d: got v=%b bits=%h rdy=%b need 1/%h/0", k, io_pcie_out_valid, io_pcie_out_bits[31:0], io_pcie_in_ready, 32'hA5A5_0000 | 32'(200 + k)); end
            @(posedge clock);
            @(negedge clock);
        end
        n_vec++; if (io_pcie_out_valid !== 1'b0) begin n_err++; $display("FAIL ctrl_drained: got %b need 0", io_pcie_out_valid); end
        io_pcie_in_valid = 1'b0;
        csr_req(1'b1, 32'd5, 64'd2, d, v);
        csr_req(1'b0, 32'd2, 64'd0, d, v);
        n_vec++; if (d !== 64'd0) begin n_err++; $display("FAIL clr_in_count: got %0d need 0", d); end
        csr_req(1'b0, 32'd3, 64'd0, d, v);
        n_vec++; if (d !== 64'd0) begin n_err++; $display("FAIL clr_out_count: got %0d need 0", d); end
        csr_req(1'b0, 32'd5, 64'd0, d, v);
        n_vec++; if (d !== 64'd0) begin n_err++; $display("FAIL clr_ctrl_read: got %h need 0", d); end
        csr_req(1'b1, 32'd5, 64'd1, d, v);
        n_vec++; if (io_pcie_in_ready !== 1'b1) begin n_err++; $display("FAIL ctrl_reenable: got %b need 1", io_pcie_in_ready); end
    endtask

    task automatic test_reset_midop();
        logic [63:0] d; logic v;
        io_pcie_out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            io_pcie_in_valid = 1'b1;
            io_pcie_in_bits  = beat(400 + k);
            @(posedge clock);
            @(negedge clock);
        end
        io_pcie_in_valid = 1'b0;
        csr_req(1'b1, 32'd5, 64'd0, d, v);
        io_softreg_resp_ready    = 1'b0;
        io_softreg_req_valid     = 1'b1;
        io_softreg_req_bits_wr   = 1'b0;
        io_softreg_req_bits_addr = 32'd0;
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        n_vec++; if (io_pcie_out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid: got %b need 0", io_pcie_out_valid); end
        n_vec++; if (io_softreg_resp_valid !== 1'b0 || io_softreg_resp_bits_rdata !== 64'd0) begin n_err++; $display("FAIL midrst_resp: got v=%b d=%h need 0/0", io_softreg_resp_valid, io_softreg_resp_bits_rdata); end
        n_vec++; if (io_pcie_in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready: got %b need 1", io_pcie_in_ready); end
        @(negedge clock);
        reset = 1'b0;
        io_softreg_req_valid  = 1'b0;
        io_softreg_resp_ready = 1'b1;
        io_pcie_out_ready     = 1'b1;
        @(negedge clock);
        csr_req(1'b0, 32'd4, 64'd0, d, v);
        n_vec++; if (d !== 64'd0) begin n_err++; $display("FAIL midrst_level: got %0d need 0", d); end
        csr_req(1'b0, 32'd1, 64'd0, d, v);
        n_vec++; if (d !== 64'd0) begin n_err++; $display("FAIL midrst_scratch: got %h need 0", d); end
    endtask

    initial begin
        reset                     = 1'b1;
        io_pcie_in_valid          = 1'b0;
        io_pcie_in_bits           = 640'd0;
        io_pcie_out_ready         = 1'b0;
        io_softreg_req_valid      = 1'b0;
        io_softreg_req_bits_addr  = 32'd0;
        io_softreg_req_bits_wdata = 64'd0;
        io_softreg_req_bits_wr    = 1'b0;
        io_softreg_resp_ready     = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        test_reset();
        test_scratch();
        test_fill_drain();
        test_resp_hold();
        test_perf();
        test_ctrl();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
